video_timing_gen: RTL

//  Free-running 1080p60 raster timing generator for the CeNN pipeline (2200x1125 total raster).

---
 rtl/video_timing_pkg.sv | 42 ++++
 rtl/video_timing_gen_sync_delay_line.sv | 37 +++
 rtl/video_timing_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants, widths and sync-bundle type for the 1080p60 raster timing generator.
`timescale 1ns/1ps
package video_timing_pkg;

   localparam int X_W = 12;
   localparam int Y_W = 11;

   localparam int DEF_H_ACTIVE = 1920;
   localparam int DEF_H_FP     = 88;
   localparam int DEF_H_SYNC   = 44;
   localparam int DEF_H_BP     = 148;
   localparam int DEF_V_ACTIVE = 1080;
   localparam int DEF_V_FP     = 4;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 36;
   localparam int DEF_PIPE_LAT = 8;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
      logic sof;
   } vid_sync_t;

   function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = raster_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = raster_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   // Value a sync bundle takes outside active video and while in reset.
   function automatic vid_sync_t sync_idle(input logic pol);
      vid_sync_t s;
      s.de    = 1'b0;
      s.hsync = ~pol;
      s.vsync = ~pol;
      s.sof   = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Clock-enabled shift register of sync bundles; realigns timing with the CeNN output latency.
`timescale 1ns/1ps
module sync_delay_line
   import video_timing_pkg::*;
#(
   parameter int        DEPTH = 8,
   parameter vid_sync_t IDLE  = '0
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   input  vid_sync_t din,
   output vid_sync_t dout
);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      vid_sync_t stage_reg;
      vid_sync_t stage_in;

      if (gi == 0) begin : g_head
         assign stage_in = din;
      end else begin : g_tail
         assign stage_in = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            stage_reg <= IDLE;
         end else if (en) begin
            stage_reg <= stage_in;
         end
      end
   end

   assign dout = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator with a delayed copy of the sync bundle.
`timescale 1ns/1ps
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b1,
   parameter int   PIPE_LAT = DEF_PIPE_LAT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           de,
   output logic           hsync,
   output logic           vsync,
   output logic           sof,
   output logic           de_d,
   output logic           hsync_d,
   output logic           vsync_d,
   output logic           sof_d
);

   localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] X_ACT      = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] X_HS_START = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] X_HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_ACT      = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] Y_VS_START = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] Y_VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   localparam vid_sync_t SYNC_IDLE = sync_idle(SYNC_POL);

   if (PIPE_LAT < 1 || PIPE_LAT > 64) begin : g_bad_lat
      $error("video_timing_gen: PIPE_LAT=%0d outside 1..64", PIPE_LAT);
   end
   if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_raster
      $error("video_timing_gen: raster %0dx%0d exceeds counter widths", H_TOTAL, V_TOTAL);
   end

   // pos_* is the raster slot the next enabled edge presents on the outputs,
   // so the first edge after reset shows slot (0,0) rather than skipping it.
   logic [X_W-1:0] pos_x_reg, pos_x_next;
   logic [Y_W-1:0] pos_y_reg, pos_y_next;
   logic [X_W-1:0] x_reg;
   logic [Y_W-1:0] y_reg;
   vid_sync_t      sync_reg, sync_next;
   vid_sync_t      sync_dly;

   always_comb begin
      pos_x_next = pos_x_reg + X_W'(1);
      pos_y_next = pos_y_reg;
      if (pos_x_reg == X_LAST) begin
         pos_x_next = '0;
         pos_y_next = (pos_y_reg == Y_LAST) ? '0 : pos_y_reg + Y_W'(1);
      end
   end

   always_comb begin
      sync_next       = SYNC_IDLE;
      sync_next.de    = (pos_x_reg < X_ACT) && (pos_y_reg < Y_ACT);
      sync_next.hsync = (pos_x_reg >= X_HS_START && pos_x_reg < X_HS_END) ? SYNC_POL : ~SYNC_POL;
      sync_next.vsync = (pos_y_reg >= Y_VS_START && pos_y_reg < Y_VS_END) ? SYNC_POL : ~SYNC_POL;
      sync_next.sof   = (pos_x_reg == '0) && (pos_y_reg == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_x_reg <= '0;
         pos_y_reg <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         sync_reg  <= SYNC_IDLE;
      end else if (en) begin
         pos_x_reg <= pos_x_next;
         pos_y_reg <= pos_y_next;
         x_reg     <= pos_x_reg;
         y_reg     <= pos_y_reg;
         sync_reg  <= sync_next;
      end
   end

   // Fed from the registered outputs, so DEPTH stages give exactly PIPE_LAT enabled clocks of delay.
   sync_delay_line #(
      .DEPTH (PIPE_LAT),
      .IDLE  (SYNC_IDLE)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .din   (sync_reg),
      .dout  (sync_dly)
   );

   assign x       = x_reg;
   assign y       = y_reg;
   assign de      = sync_reg.de;
   assign hsync   = sync_reg.hsync;
   assign vsync   = sync_reg.vsync;
   assign sof     = sync_reg.sof;
   assign de_d    = sync_dly.de;
   assign hsync_d = sync_dly.hsync;
   assign vsync_d = sync_dly.vsync;
   assign sof_d   = sync_dly.sof;

endmodule
